// File: rtl/spi_seq_swc.sv
// SPI transaction sequencer: runs one command (CR write, TX stream into WDR,
// SR poll, RDR read-back) as an APB master on behalf of a local requester.
module spi_seq_swc #(
  parameter logic [31:0] SPI_BASE   = 32'h0010_0000,
  parameter int          POLL_LIMIT = 4096,
  parameter int          PCNT_W     = 13
) (
  input  logic        pclk,
  input  logic        prst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_cr,
  input  logic [4:0]  req_len,
  input  logic        tx_valid,
  output logic        tx_ready,
  input  logic [15:0] tx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic [15:0] rx_data,
  output logic        done,
  output logic [1:0]  err,
  output logic [31:0] paddr,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] pwdata,
  input  logic        pready,
  input  logic [31:0] prdata,
  input  logic        pslverr
);

  typedef enum logic [2:0] {S_IDLE, S_WR_CR, S_WR_TX, S_POLL, S_RD_RX, S_FIN} state_t;
  typedef enum logic [1:0] {A_IDLE, A_SETUP, A_ACCESS} aph_t;

  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(POLL_LIMIT - 1);

  state_t             state_q, state_d;
  aph_t               aph_q, aph_d;
  logic [4:0]         len_q, len_d;
  logic [4:0]         wcnt_q, wcnt_d;
  logic [PCNT_W-1:0]  pcnt_q, pcnt_d;
  logic [31:0]        paddr_q, paddr_d;
  logic [31:0]        pwdata_q, pwdata_d;
  logic               pwrite_q, pwrite_d;
  logic               rx_valid_q, rx_valid_d;
  logic [15:0]        rx_data_q, rx_data_d;
  logic [1:0]         err_q, err_d;

  logic xfer_done;
  logic apb_free;
  logic unused_prdata_hi;

  assign xfer_done        = (aph_q == A_ACCESS) && pready;
  assign apb_free         = (aph_q == A_IDLE);
  assign unused_prdata_hi = ^prdata[31:16];

  always_comb begin
    state_d    = state_q;
    aph_d      = aph_q;
    len_d      = len_q;
    wcnt_d     = wcnt_q;
    pcnt_d     = pcnt_q;
    paddr_d    = paddr_q;
    pwdata_d   = pwdata_q;
    pwrite_d   = pwrite_q;
    rx_valid_d = rx_valid_q;
    rx_data_d  = rx_data_q;
    err_d      = err_q;

    case (aph_q)
      A_SETUP:  aph_d = A_ACCESS;
      A_ACCESS: if (pready) aph_d = A_IDLE;
      default:  ;
    endcase

    // A new transfer is only launched from A_IDLE, which guarantees the
    // one-cycle psel release between back-to-back transfers.
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d  = S_WR_CR;
          len_d    = req_len;
          wcnt_d   = 5'd0;
          pcnt_d   = '0;
          err_d    = 2'd0;
          aph_d    = A_SETUP;
          paddr_d  = SPI_BASE;
          pwdata_d = req_cr;
          pwrite_d = 1'b1;
        end
      end
      S_WR_CR: begin
        if (xfer_done) begin
          if (pslverr) begin
            state_d = S_FIN;
            err_d   = 2'd1;
          end else if (len_q == 5'd0) begin
            state_d = S_POLL;
          end else begin
            state_d = S_WR_TX;
          end
        end
      end
      S_WR_TX: begin
        if (xfer_done) begin
          wcnt_d = wcnt_q + 5'd1;
          if (pslverr) begin
            state_d = S_FIN;
            err_d   = 2'd1;
          end else if (wcnt_q + 5'd1 == len_q) begin
            state_d = S_POLL;
          end
        end else if (apb_free && tx_valid) begin
          aph_d    = A_SETUP;
          paddr_d  = SPI_BASE + 32'h8;
          pwdata_d = {16'h0000, tx_data};
          pwrite_d = 1'b1;
        end
      end
      S_POLL: begin
        if (xfer_done) begin
          if (pslverr) begin
            state_d = S_FIN;
            err_d   = 2'd1;
          end else if (!prdata[7] && !prdata[1]) begin
            if (len_q == 5'd0) begin
              state_d = S_FIN;
            end else begin
              state_d = S_RD_RX;
              wcnt_d  = 5'd0;
            end
          end else begin
            if (pcnt_q != '1) pcnt_d = pcnt_q + 1'b1;
            if (pcnt_q >= PCNT_LAST) begin
              state_d = S_FIN;
              err_d   = 2'd2;
            end
          end
        end else if (apb_free) begin
          aph_d    = A_SETUP;
          paddr_d  = SPI_BASE + 32'h4;
          pwrite_d = 1'b0;
        end
      end
      S_RD_RX: begin
        if (xfer_done) begin
          if (pslverr) begin
            state_d = S_FIN;
            err_d   = 2'd1;
          end else begin
            rx_valid_d = 1'b1;
            rx_data_d  = prdata[15:0];
            wcnt_d     = wcnt_q + 5'd1;
          end
        end else if (rx_valid_q) begin
          // The accepting cycle never launches the next read.
          if (rx_ready) begin
            rx_valid_d = 1'b0;
            if (wcnt_q == len_q) state_d = S_FIN;
          end
        end else if (apb_free) begin
          aph_d    = A_SETUP;
          paddr_d  = SPI_BASE + 32'hC;
          pwrite_d = 1'b0;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (prst) begin
      state_q    <= S_IDLE;
      aph_q      <= A_IDLE;
      len_q      <= 5'd0;
      wcnt_q     <= 5'd0;
      pcnt_q     <= '0;
      paddr_q    <= 32'h0;
      pwdata_q   <= 32'h0;
      pwrite_q   <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= 16'h0;
      err_q      <= 2'd0;
    end else begin
      state_q    <= state_d;
      aph_q      <= aph_d;
      len_q      <= len_d;
      wcnt_q     <= wcnt_d;
      pcnt_q     <= pcnt_d;
      paddr_q    <= paddr_d;
      pwdata_q   <= pwdata_d;
      pwrite_q   <= pwrite_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      err_q      <= err_d;
    end
  end

  assign req_ready = (state_q == S_IDLE) && !prst;
  assign tx_ready  = (state_q == S_WR_TX) && xfer_done && !prst;
  assign rx_valid  = rx_valid_q;
  assign rx_data   = rx_data_q;
  assign done      = (state_q == S_FIN);
  assign err       = err_q;
  assign paddr     = paddr_q;
  assign psel      = (aph_q != A_IDLE);
  assign penable   = (aph_q == A_ACCESS);
  assign pwrite    = pwrite_q;
  assign pwdata    = pwdata_q;

endmodule

// File: tb/tb_spi_seq_swc.sv
// Scoreboard bench for spi_seq_swc: a command-level model predicts the APB
// transfer list, RX words, consumed TX count and error code of each command.
`timescale 1ns/1ps
module tb_spi_seq_swc;
  localparam logic [31:0] BASE = 32'h0010_0000;
  localparam int PL = 8;

  logic        pclk = 1'b0;
  logic        prst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_cr = 32'h0;
  logic [4:0]  req_len = 5'd0;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [15:0] tx_data = 16'h0;
  logic        rx_valid;
  logic        rx_ready = 1'b0;
  logic [15:0] rx_data;
  logic        done;
  logic [1:0]  err;
  logic [31:0] paddr;
  logic        psel, penable, pwrite;
  logic [31:0] pwdata;
  logic        pready = 1'b0;
  logic [31:0] prdata = 32'h0;
  logic        pslverr = 1'b0;

  spi_seq_swc #(.SPI_BASE(BASE), .POLL_LIMIT(PL), .PCNT_W(4)) dut (
    .pclk(pclk), .prst(prst),
    .req_valid(req_valid), .req_ready(req_ready), .req_cr(req_cr), .req_len(req_len),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
    .done(done), .err(err),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
    .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  typedef struct packed {
    logic [31:0] a;
    logic        w;
    logic [31:0] d;
  } apb_t;

  apb_t        apb_exp[$];
  logic [15:0] rx_exp[$];
  logic [1:0]  err_exp[$];
  int          cons_exp[$];
  logic [15:0] txq[$];
  logic [15:0] tx_words[16];
  logic [15:0] rd_vals[16];

  int total = 0;
  int bad = 0;
  int busy_cfg = 0, err_at_cfg = -1, stall_left = 0;
  bit gap_alt = 0, hold_pready = 0;
  int xfer_idx = 0, sr_idx = 0, rd_idx = 0, wait_left = 0;
  int tx_cons = 0, done_cnt = 0, model_idx = 0;
  bit done_seen = 0, tx_taken = 0, gap_skip = 0, rx_hold = 0;
  logic [15:0] rx_prev = 16'h0;
  apb_t        cur;
  logic [31:0] w32;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic bit add_x(input logic [31:0] a, input logic w, input logic [31:0] d);
    apb_t t;
    t.a = a; t.w = w; t.d = d;
    apb_exp.push_back(t);
    add_x = (model_idx == err_at_cfg);
    model_idx++;
  endfunction

  // Slave, TX producer and RX consumer drive on the falling edge; handshakes
  // are observed 2 ns later, still well before the next rising edge.
  always @(negedge pclk) begin
    pready  = 1'b0;
    pslverr = 1'b0;
    prdata  = $urandom;
    if (!prst && psel && !penable) begin
      wait_left = $urandom_range(0, 2);
    end else if (!prst && psel && penable && !hold_pready) begin
      if (wait_left > 0) begin
        wait_left--;
      end else begin
        pready  = 1'b1;
        pslverr = (xfer_idx == err_at_cfg);
        if (apb_exp.size() == 0) begin
          total++; bad++;
          $display("FAIL apb_unexpected actual addr=%h write=%0d required=none", paddr, pwrite);
        end else begin
          cur = apb_exp.pop_front();
          chk("apb_addr", paddr, cur.a);
          chk("apb_write", 32'(pwrite), 32'(cur.w));
          if (cur.w) chk("apb_wdata", pwdata, cur.d);
        end
        if (!pwrite && paddr == BASE + 32'h4) begin
          w32 = $urandom;
          if (sr_idx < busy_cfg) begin
            case ($urandom_range(0, 2))
              0: w32[7] = 1'b1;
              1: w32[1] = 1'b1;
              default: begin w32[7] = 1'b1; w32[1] = 1'b1; end
            endcase
          end else begin
            w32[7] = 1'b0; w32[1] = 1'b0;
          end
          prdata = w32;
          sr_idx++;
        end else if (!pwrite && paddr == BASE + 32'hC) begin
          chk("rdr_read_while_rx_valid", 32'(rx_valid), 32'd0);
          w32 = $urandom;
          prdata = {w32[31:16], rd_vals[rd_idx % 16]};
          rd_idx++;
        end
        xfer_idx++;
      end
    end

    if (tx_taken) begin
      tx_taken = 0;
      if (txq.size() > 0) txq.delete(0);
      tx_valid = 1'b0;
      gap_skip = gap_alt;
    end
    if (txq.size() == 0) begin
      tx_valid = 1'b0;
    end else if (!tx_valid) begin
      if (gap_skip) gap_skip = 0;
      else if (gap_alt || $urandom_range(0, 2) != 0) begin
        tx_valid = 1'b1;
        tx_data  = txq[0];
      end
    end

    if (stall_left > 0) begin
      rx_ready = 1'b0;
      if (rx_valid) stall_left--;
    end else begin
      rx_ready = ($urandom_range(0, 3) != 0);
    end

    #2;
    if (!prst) begin
      if (tx_valid && tx_ready) begin
        tx_taken = 1;
        tx_cons++;
      end
      if (tx_ready || (psel && penable && pready && pwrite && paddr == BASE + 32'h8))
        chk("tx_ready_on_wdr_done", 32'(tx_ready),
            32'(psel && penable && pready && pwrite && paddr == BASE + 32'h8));
      if (rx_hold) begin
        chk("rx_valid_held", 32'(rx_valid), 32'd1);
        chk("rx_data_held", 32'(rx_data), 32'(rx_prev));
      end
      rx_hold = 0;
      if (rx_valid && rx_ready) begin
        if (rx_exp.size() == 0) begin
          total++; bad++;
          $display("FAIL rx_unexpected actual=%h required=none", rx_data);
        end else begin
          chk("rx_data", 32'(rx_data), 32'(rx_exp.pop_front()));
        end
      end else if (rx_valid) begin
        rx_hold = 1;
        rx_prev = rx_data;
      end
      if (done) begin
        done_cnt++;
        done_seen = 1;
        if (err_exp.size() == 0) begin
          total++; bad++;
          $display("FAIL done_unexpected actual err=%0d required=no done", err);
        end else begin
          chk("err", 32'(err), 32'(err_exp.pop_front()));
          chk("tx_consumed", 32'(tx_cons), 32'(cons_exp.pop_front()));
          chk("apb_left", 32'(apb_exp.size()), 32'd0);
          chk("rx_left", 32'(rx_exp.size()), 32'd0);
        end
      end
    end else begin
      rx_hold = 0;
    end
  end

  task automatic issue_req(input logic [31:0] cr, input int len);
    bit acc = 0;
    @(negedge pclk);
    req_valid = 1'b1;
    req_cr    = cr;
    req_len   = 5'(len);
    for (int c = 0; c < 50 && !acc; c++) begin
      #2;
      if (req_ready) acc = 1;
      @(negedge pclk);
    end
    req_valid = 1'b0;
    if (!acc) begin
      total++; bad++;
      $display("FAIL accept_timeout actual=no accept required=accept");
    end else begin
      chk("setup_psel", 32'(psel), 32'd1);
      chk("setup_penable", 32'(penable), 32'd0);
      chk("setup_paddr", paddr, BASE);
    end
  endtask

  task automatic run_cmd(input logic [31:0] cr, input int len, input int busy,
                         input int err_at, input int stall, input bit alt);
    bit abort, ok_poll;
    int cons;
    logic [1:0] e;
    busy_cfg = busy; err_at_cfg = err_at; gap_alt = alt; gap_skip = 0;
    xfer_idx = 0; sr_idx = 0; rd_idx = 0; tx_cons = 0; model_idx = 0;
    done_seen = 0;
    for (int i = 0; i < len; i++) txq.push_back(tx_words[i]);

    cons = 0;
    abort = add_x(BASE, 1'b1, cr);
    for (int i = 0; i < len && !abort; i++) begin
      abort = add_x(BASE + 32'h8, 1'b1, {16'h0, tx_words[i]});
      cons++;
    end
    ok_poll = 0;
    if (!abort) begin
      for (int k = 0; k < PL; k++) begin
        abort = add_x(BASE + 32'h4, 1'b0, 32'h0);
        if (abort) break;
        if (k >= busy) begin ok_poll = 1; break; end
      end
    end
    if (abort) e = 2'd1;
    else if (!ok_poll) e = 2'd2;
    else begin
      e = 2'd0;
      for (int i = 0; i < len; i++) begin
        abort = add_x(BASE + 32'hC, 1'b0, 32'h0);
        if (abort) begin e = 2'd1; break; end
        rx_exp.push_back(rd_vals[i]);
      end
    end
    err_exp.push_back(e);
    cons_exp.push_back(cons);

    stall_left = stall;
    issue_req(cr, len);
    for (int c = 0; c < 3000 && !done_seen; c++) @(negedge pclk);
    if (!done_seen) begin
      total++; bad++;
      $display("FAIL done_timeout actual=no done required=done len=%0d", len);
      apb_exp.delete(); rx_exp.delete(); err_exp.delete(); cons_exp.delete();
    end
    @(negedge pclk);
    txq.delete();
    repeat (2) @(negedge pclk);
  endtask

  task automatic rand_words();
    for (int i = 0; i < 16; i++) begin
      tx_words[i] = 16'($urandom);
      rd_vals[i]  = 16'($urandom);
    end
  endtask

  initial begin
    int saved_done;
    bit seen_access;
    repeat (3) @(negedge pclk);
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    prst = 1'b0;
    @(negedge pclk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_psel", 32'(psel), 32'd0);
    chk("rst_penable", 32'(penable), 32'd0);
    chk("rst_pwrite", 32'(pwrite), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_tx_ready", 32'(tx_ready), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_paddr", paddr, 32'h0);
    chk("rst_pwdata", pwdata, 32'h0);
    chk("rst_rx_data", 32'(rx_data), 32'd0);

    // Single word, idle SR on the first poll.
    rand_words();
    tx_words[0] = 16'h00A5;
    rd_vals[0]  = 16'h005A;
    run_cmd(32'h0000_0040, 1, 0, -1, 0, 0);

    // Sixteen words with every other TX slot empty.
    rand_words();
    for (int i = 0; i < 16; i++) tx_words[i] = 16'(i);
    run_cmd(32'h1234_5678, 16, 1, -1, 0, 1);

    // Slave error on the third WDR write.
    rand_words();
    run_cmd(32'h0000_0011, 4, 0, 3, 0, 0);

    // SR stays busy: poll timeout.
    rand_words();
    run_cmd(32'h0000_0022, 2, 100, -1, 0, 0);

    // First RX word held off for 10 cycles.
    rand_words();
    run_cmd(32'h0000_0033, 3, 2, -1, 10, 0);

    // Zero-length command.
    run_cmd(32'h0000_0044, 0, 1, -1, 0, 0);

    // Reset while the CR write sits in ACCESS with pready low.
    hold_pready = 1;
    err_at_cfg  = -1;
    saved_done  = done_cnt;
    issue_req(32'h0000_0055, 2);
    seen_access = 0;
    for (int c = 0; c < 10 && !seen_access; c++) begin
      if (psel && penable) seen_access = 1;
      else @(negedge pclk);
    end
    chk("access_reached", 32'(seen_access), 32'd1);
    prst = 1'b1;
    @(negedge pclk);
    chk("rst_mid_psel", 32'(psel), 32'd0);
    chk("rst_mid_req_ready", 32'(req_ready), 32'd0);
    prst = 1'b0;
    hold_pready = 0;
    #1;
    chk("rst_mid_req_ready_after", 32'(req_ready), 32'd1);
    repeat (20) @(negedge pclk);
    chk("rst_mid_no_done", 32'(done_cnt), 32'(saved_done));
    apb_exp.delete(); rx_exp.delete(); err_exp.delete(); cons_exp.delete(); txq.delete();

    rand_words();
    run_cmd(32'h0000_0066, 5, 0, -1, 0, 0);

    for (int n = 0; n < 25; n++) begin
      int len, busy, ea, st;
      rand_words();
      len  = $urandom_range(0, 16);
      busy = ($urandom_range(0, 5) == 0) ? 9 : $urandom_range(0, 3);
      ea   = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 2 * len + 2) : -1;
      st   = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 6) : 0;
      run_cmd($urandom, len, busy, ea, st, $urandom_range(0, 1) == 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spi_seq_swc.md
# spi_seq_swc

SPI transaction sequencer: APB master that drives the SPI controller's register file (CR/SR/WDR/RDR) on behalf of one local requester. It takes one command (CR value + word count), writes CR, streams TX words into WDR, polls SR until the link is idle, then reads back one RDR word per TX word and streams it out. It sits between a local engine (CPU offload / boot loader) and the SPI peripheral's APB slave port, replacing software polling loops.

## Interface
- SPI_BASE, 32'h0010_0000, APB base of SPI block; CR=+0x0, SR=+0x4, WDR=+0x8, RDR=+0xC
- POLL_LIMIT, 4096, max SR reads per command before timeout (≥1)
- PCNT_W, 13, width of poll counter (must hold POLL_LIMIT)

- pclk  in  1  clock; all logic on rising edge
- prst  in  1  synchronous reset, active-high
- req_valid  in  1  command offered
- req_ready  out  1  sequencer idle, command accepted on req_valid&&req_ready
- req_cr  in  32  value written to CR
- req_len  in  5  words to transfer, 0..16
- tx_valid  in  1  TX word available
- tx_ready  out  1  TX word consumed this cycle
- tx_data  in  16  TX word
- rx_valid  out  1  RX word presented
- rx_ready  in  1  RX word accepted
- rx_data  out  16  RX word (prdata[15:0] of RDR read)
- done  out  1  one-cycle pulse, command finished (ok or error)
- err  out  2  valid with done: 0 ok, 1 pslverr, 2 poll timeout
- paddr  out  32 / psel out 1 / penable out 1 / pwrite out 1 / pwdata out 32  APB master request
- pready in 1 / prdata in 32 / pslverr in 1  APB completion

## Operation
- Main FSM: IDLE → WR_CR → WR_TX → POLL → RD_RX → FIN → IDLE.
- IDLE: req_ready=1. On accept, latch req_cr, req_len; clear word counter wcnt and poll counter pcnt.
- WR_CR: one APB write, paddr=SPI_BASE, pwdata=latched cr.
- WR_TX: while wcnt<len: wait tx_valid; then APB write to WDR, pwdata={16'b0,tx_data}; tx_ready pulses in the cycle the write completes (pready); wcnt++. len=0 skips WR_TX and RD_RX (CR write + POLL only).
- POLL: APB read of SR; complete when prdata[7]==0 (BSY) and prdata[1]==0 (TX pending); else pcnt++ and reissue. pcnt reaching POLL_LIMIT with condition unmet → FIN, err=2.
- RD_RX: wcnt reset to 0; for each word: wait rx_ready-free slot (rx_valid low), APB read of RDR; on pready latch prdata[15:0] to rx_data, assert rx_valid; hold until rx_ready; wcnt++ until len.
- FIN: done=1 one cycle with err; → IDLE.
- pslverr sampled with pready on any transfer → abort remaining steps, FIN with err=1. TX word of a failed WDR write is still consumed.
- APB sub-FSM per transfer: SETUP (psel=1, penable=0, address/data/pwrite valid) → ACCESS (psel=1, penable=1, hold all until pready) → release (psel=0) for at least one cycle before next SETUP.

## Timing
- Reset: req_ready=0 during reset, 1 first cycle after; tx_ready, rx_valid, done, psel, penable, pwrite=0; paddr, pwdata, rx_data, err=0; FSMs to IDLE. Reset mid-transfer drops psel immediately next edge; no completion, no done.
- Accept at edge N → SETUP for CR at N+1, ACCESS at N+2.
- Zero-wait slave: each APB transfer = 3 cycles incl. idle gap; command len L, SR idle on first poll: total ≈ 3·(2+2L) + 2 cycles accept→done.
- req_valid ignored outside IDLE; tx_ready never asserted outside WR_TX; rx_valid held stable with rx_data until rx_ready.
- Simultaneous rx_ready and pready: rx word accepted, next read not issued in same cycle.
- pcnt saturates; wcnt width 5 bits, no wrap (len ≤16).

## Test plan
- len=1, cr=0x0000_0040, tx=0xA5, slave SR=0 first poll, RDR=0x005A → APB sequence W CR 0x40, W WDR 0xA5, R SR, R RDR; rx_data=0x005A once; done with err=0.
- len=16, tx 0x0000..0x000F, tx_valid gapped every other word → 16 WDR writes in order, 16 RX words in order, done err=0.
- pslverr on 3rd WDR write of len=4 → no further APB accesses, done err=1, tx consumed exactly 3 words.
- POLL_LIMIT=8, SR prdata=0x80 forever → exactly 8 SR reads, done err=2, no RDR read.
- rx_ready held low 10 cycles on word 0 → rx_valid/rx_data stable, no RDR read issued until accepted.
- prst pulsed while ACCESS held with pready=0 → psel=0 next cycle, no done, req_ready=1 after reset; new command runs normally.
